lsu_mem_port: RTL and testbench

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

---
 rtl/lsu_mem_port.sv | 122 ++++++++++++
 tb/tb_lsu_mem_port.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: accepts one request at a time, issues a single
// word-aligned memory command, and returns an aligned, extended result.
module lsu_mem_port (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_byte_en,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} state_t;

  state_t      state, state_nx;
  logic        we_q, err_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic        legal, aligned, req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  always_comb begin
    legal   = 1'b0;
    aligned = 1'b1;
    case (req_funct3)
      3'b000:         legal = 1'b1;
      3'b001:         begin legal = 1'b1;    aligned = ~req_addr[0];          end
      3'b010:         begin legal = 1'b1;    aligned = (req_addr[1:0] == 2'b00); end
      3'b100:         legal = ~req_we;
      3'b101:         begin legal = ~req_we; aligned = ~req_addr[0];          end
      default:        legal = 1'b0;
    endcase
    req_err = ~(legal & aligned);
  end

  // Lane selection uses the captured address; extension follows captured funct3.
  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (addr_q[1:0])
      2'b00: byte_sel = mem_rdata[7:0];
      2'b01: byte_sel = mem_rdata[15:8];
      2'b10: byte_sel = mem_rdata[23:16];
      2'b11: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = req_err ? RESP : ISSUE;
      ISSUE:   if (mem_ready) state_nx = we_q ? RESP : WAIT_R;
      WAIT_R:  if (mem_rvalid) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        we_q     <= req_we;
        err_q    <= req_err;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        be_q     <= req_byte_en;
        rdata_q  <= '0;
      end
      if (state == WAIT_R && mem_rvalid) rdata_q <= load_data;
    end
  end

  // Memory and response outputs are forced to zero outside their owning state.
  always_comb begin
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    mem_valid  = (state == ISSUE);
    mem_we     = mem_valid & we_q;
    mem_addr   = mem_valid ? {addr_q[31:2], 2'b00} : '0;
    mem_wdata  = mem_valid ? wdata_q : '0;
    mem_be     = mem_valid ? (we_q ? be_q : 4'b1111) : '0;
    resp_valid = (state == RESP);
    resp_rdata = resp_valid ? rdata_q : '0;
    resp_err   = resp_valid & err_q;
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a response scoreboard checked on resp_valid.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_byte_en;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  lsu_mem_port dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_byte_en(req_byte_en),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_resp: observed resp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic check_issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be);
    @(negedge clk);
    chk("mem_valid", {31'd0, mem_valid}, 32'd1);
    chk("mem_we", {31'd0, mem_we}, {31'd0, we});
    chk("mem_addr", mem_addr, {a[31:2], 2'b00});
    chk("mem_be", {28'd0, mem_be}, {28'd0, (we ? be : 4'b1111)});
    if (we) chk("mem_wdata", mem_wdata, wd);
  endtask

  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be, input logic [31:0] rd,
                         input int unsigned delay, input logic exp_err,
                         input logic [31:0] exp_rdata);
    exp_t e;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a;
    req_wdata = wd; req_byte_en = be;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.cyc   = cyc + (exp_err ? 1 : (we ? 2 + delay : 3 + delay));
    sb.push_back(e);
    @(posedge clk) #1;
    req_valid = 1'b0;
    if (exp_err) begin
      @(negedge clk);
      chk("err_no_mem_valid", {31'd0, mem_valid}, 32'd0);
      @(posedge clk) #1;
    end else begin
      mem_ready = 1'b0;
      for (int unsigned i = 0; i < delay; i++) begin
        check_issue(we, a, wd, be);
        @(posedge clk) #1;
      end
      mem_ready = 1'b1;
      check_issue(we, a, wd, be);
      @(posedge clk) #1;
      mem_ready = 1'b0;
      if (!we) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        @(posedge clk) #1;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end
      @(posedge clk) #1;
    end
  endtask

  initial begin
    int unsigned a0;
    reset_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'h1234_5678; req_byte_en = 4'b1111;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_ctl", {28'd0, mem_valid, mem_we, resp_valid, resp_err}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    @(posedge clk) #1;
    req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    reset_n = 1'b1;
    @(posedge clk) #1;

    // Loads: sign/zero extension and lane selection
    run_req(1'b0, 3'b000, 32'h103, 32'h0, 4'h0, 32'h80FF_1234, 0, 1'b0, 32'hFFFF_FF80);
    run_req(1'b0, 3'b101, 32'h102, 32'h0, 4'h0, 32'h8001_0000, 0, 1'b0, 32'h0000_8001);
    run_req(1'b0, 3'b001, 32'h102, 32'h0, 4'h0, 32'h8001_0000, 0, 1'b0, 32'hFFFF_8001);
    run_req(1'b0, 3'b100, 32'h101, 32'h0, 4'h0, 32'h1234_5678, 0, 1'b0, 32'h0000_0056);
    run_req(1'b0, 3'b010, 32'h104, 32'h0, 4'h0, 32'hDEAD_BEEF, 2, 1'b0, 32'hDEAD_BEEF);
    // Stores, including stalled mem_ready
    run_req(1'b1, 3'b000, 32'h201, 32'hABAB_ABAB, 4'b0010, 32'h0, 3, 1'b0, 32'h0);
    run_req(1'b1, 3'b001, 32'h206, 32'h5A5A_5A5A, 4'b1100, 32'h0, 0, 1'b0, 32'h0);
    // Errors: misaligned word store, illegal load funct3, store with load-only funct3
    run_req(1'b1, 3'b010, 32'h202, 32'h1111_1111, 4'b1111, 32'h0, 0, 1'b1, 32'h0);
    run_req(1'b0, 3'b011, 32'h100, 32'h0, 4'h0, 32'h0, 0, 1'b1, 32'h0);
    run_req(1'b1, 3'b100, 32'h100, 32'h0, 4'h1, 32'h0, 0, 1'b1, 32'h0);
    run_req(1'b0, 3'b001, 32'h101, 32'h0, 4'h0, 32'h0, 0, 1'b1, 32'h0);

    // Reset while waiting for read data, then a late mem_rvalid
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
    @(posedge clk) #1;
    req_valid = 1'b0; mem_ready = 1'b1;
    @(posedge clk) #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("wait_r_busy", {31'd0, busy}, 32'd1);
    @(posedge clk) #1;
    reset_n = 1'b0;
    @(posedge clk) #1;
    reset_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk) #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rvalid_idle", {30'd0, req_ready, busy}, 32'd2);
    @(posedge clk) #1;

    // Back-to-back stores with req_valid held high and mem_ready always 1
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h400;
    req_wdata = 32'h0BAD_F00D; req_byte_en = 4'b1111; mem_ready = 1'b1;
    a0 = cyc;
    sb.push_back('{32'h0, 1'b0, a0 + 2});
    sb.push_back('{32'h0, 1'b0, a0 + 5});
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b2b_req_ready", {31'd0, req_ready}, {31'd0, (i == 0 || i == 3)});
      @(posedge clk) #1;
    end
    req_valid = 1'b0; mem_ready = 1'b0;

    for (int unsigned i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
